// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART transmit path: line levels for the framing
// bits, the data width of one UART character, and the state encoding of the
// byte-level transmitter.
// -----------------------------------------------------------------------------
package uart_pkg;

  // Line levels of the framing bits in an 8N1 character.
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;
  localparam int   BITS_PER_BYTE = 8;

  // Byte transmitter state encoding.
  localparam logic [1:0] BYTE_IDLE  = 2'd0;
  localparam logic [1:0] BYTE_START = 2'd1;
  localparam logic [1:0] BYTE_DATA  = 2'd2;
  localparam logic [1:0] BYTE_STOP  = 2'd3;

endpackage : uart_pkg

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Serializes one byte as a UART 8N1 character (start, 8 data bits LSB first,
// stop). A new byte offered during the last stop cycle starts on the very next
// cycle, so a caller can stream characters with no idle gap.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   byte_in    in   byte to send, taken when byte_valid & byte_ready
//   byte_valid in   a byte is offered this cycle
//   byte_ready out  high in IDLE and in the last cycle of the stop bit
//   tx         out  registered UART line, idle high
// -----------------------------------------------------------------------------
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(BITS_PER_BYTE - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end    = (cnt_q == CNT_LAST);
  assign byte_ready = (state_q == BYTE_IDLE) || ((state_q == BYTE_STOP) && bit_end);
  assign tx         = tx_q;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; a missing default here would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;

    // The bit timer free-runs in every non-idle state and wraps per bit.
    if (state_q != BYTE_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      BYTE_IDLE: begin
        if (byte_valid) begin
          shreg_d = byte_in;
          state_d = BYTE_START;
          cnt_d   = '0;
          tx_d    = START_BIT;
        end
      end
      BYTE_START: begin
        if (bit_end) begin
          state_d = BYTE_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end
      BYTE_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            state_d = BYTE_STOP;
            tx_d    = STOP_BIT;
          end else begin
            // shreg_q[0] is always the bit currently on the line.
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
      end
      default: begin // BYTE_STOP
        if (bit_end) begin
          if (byte_valid) begin
            shreg_d = byte_in;
            state_d = BYTE_START;
            tx_d    = START_BIT;
          end else begin
            state_d = BYTE_IDLE;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BYTE_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule : uart_tx_byte

// File: rtl/frame_uart_tx.sv
// -----------------------------------------------------------------------------
// frame_uart_tx
// Takes a WIDTH_DIN-bit frame on a single-cycle din_valid strobe and sends it
// MSB byte first over a UART 8N1 line. One extra frame can wait in a pending
// buffer while a transmission runs; any further frame is dropped and flagged.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   din        in   frame to send, sampled only when din_valid is high
//   din_valid  in   single-cycle accept strobe (no back-pressure)
//   tx         out  registered UART line, idle high
//   busy       out  high while a frame is being shifted out
//   overflow   out  sticky: a frame was dropped; cleared only by rst
// -----------------------------------------------------------------------------
module frame_uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH_DIN    = 144,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH_DIN-1:0] din,
  input  logic                 din_valid,
  output logic                 tx,
  output logic                 busy,
  output logic                 overflow
);

  localparam int               NUM_BYTES = WIDTH_DIN / BITS_PER_BYTE;
  localparam int               IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_BYTES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [WIDTH_DIN-1:0] active_q, active_d;
  logic [WIDTH_DIN-1:0] pend_q, pend_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 overflow_q, overflow_d;

  logic [WIDTH_DIN-1:0] active_shift;
  logic [7:0]           byte_data;
  logic                 byte_valid;
  logic                 byte_ready;
  logic                 frame_done;

  // The active register shifts left one byte per character, so the byte on
  // the wire always comes from its top eight bits.
  assign active_shift = active_q << BITS_PER_BYTE;

  // While in SEND the byte engine is never idle, so byte_ready marks exactly
  // the last stop-bit cycle of the current character.
  assign frame_done = (state_q == ST_SEND) && byte_ready && (idx_q == IDX_LAST);

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    idx_d        = idx_q;
    overflow_d   = overflow_q;
    byte_valid   = 1'b0;
    byte_data    = active_q[WIDTH_DIN-1 -: BITS_PER_BYTE];

    case (state_q)
      ST_IDLE: begin
        if (din_valid) begin
          state_d    = ST_SEND;
          active_d   = din;
          idx_d      = '0;
          byte_valid = 1'b1;
          byte_data  = din[WIDTH_DIN-1 -: BITS_PER_BYTE];
        end
      end
      default: begin // ST_SEND
        if (frame_done) begin
          idx_d = '0;
          if (pend_valid_q) begin
            // Pending frame becomes active; a strobe in this same cycle
            // refills pending, so nothing is lost.
            active_d     = pend_q;
            byte_valid   = 1'b1;
            byte_data    = pend_q[WIDTH_DIN-1 -: BITS_PER_BYTE];
            pend_valid_d = din_valid;
            if (din_valid) begin
              pend_d = din;
            end
          end else if (din_valid) begin
            active_d   = din;
            byte_valid = 1'b1;
            byte_data  = din[WIDTH_DIN-1 -: BITS_PER_BYTE];
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (byte_ready) begin
            idx_d      = idx_q + IDX_W'(1);
            active_d   = active_shift;
            byte_valid = 1'b1;
            byte_data  = active_shift[WIDTH_DIN-1 -: BITS_PER_BYTE];
          end
          if (din_valid) begin
            if (!pend_valid_q) begin
              pend_d       = din;
              pend_valid_d = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      idx_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      idx_q        <= idx_d;
      overflow_q   <= overflow_d;
    end
  end

  // NOTE: the frame payload registers are deliberately left out of reset;
  // their contents are only ever read while state_q/pend_valid_q qualify them.
  always_ff @(posedge clk) begin
    active_q <= active_d;
    pend_q   <= pend_d;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .tx         (tx)
  );

  assign busy     = (state_q == ST_SEND);
  assign overflow = overflow_q;

endmodule : frame_uart_tx

// File: doc/frame_uart_tx.md
# frame_uart_tx

- Transmit-side counterpart to the frame-level compute path.
- Accepts a wide frame on a single-cycle `din_valid` pulse and serializes it MSB-byte-first onto a UART 8N1 line.
- Sits between the coprocessor's `dout`/`dout_valid` outputs and the board TX pin.
- A one-frame pending buffer absorbs a frame that arrives while a transmission is in progress.

## Interface
- `WIDTH_DIN`, default 144 (18*8): frame width in bits. Must be a multiple of 8. NUM_BYTES = WIDTH_DIN/8.
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit. Must be ≥ 2.
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `din`  in  WIDTH_DIN: frame to transmit. Sampled only when `din_valid`=1.
- `din_valid`  in  1: single-cycle accept strobe. There is no ready signal.
- `tx`  out  1: UART line. Idle level is 1.
- `busy`  out  1: high while a frame is being shifted out.
- `overflow`  out  1: sticky flag, set when a frame is dropped. Cleared only by `rst`.

## Operation
- Frame byte order: byte k (k=0..NUM_BYTES-1) is `din[WIDTH_DIN-1-8k -: 8]`, so the MSB byte is sent first.
- Bit order within a byte: LSB first.
- Byte format: start bit 0, then 8 data bits, then stop bit 1. Each bit is held for exactly CLKS_PER_BIT cycles.
- Consecutive bytes within a frame go back-to-back, with no idle gap between a stop bit and the next start bit.
- Top-level FSM states:
  - IDLE: `busy`=0, `tx`=1.
  - SEND: `busy`=1, active shift register drives the byte sub-module.
- Frame handling on each cycle:
  - IDLE, `din_valid`=1: load `din` into the active register and enter SEND.
  - SEND, pending empty, `din_valid`=1: capture `din` into pending.
  - SEND, pending full, `din_valid`=1: drop the frame and set `overflow`=1. The active frame and pending contents are unaffected.
- Frame done (the last cycle of the last stop bit):
  - Pending full: move pending into active, mark pending empty, stay in SEND. The next start bit begins on the following cycle.
  - Pending empty: go to IDLE.
- Simultaneous events in the frame-done cycle:
  - Pending full and `din_valid`=1: pending moves to active and `din` enters pending. No overflow.
  - Pending empty and `din_valid`=1: `din` loads directly into active and SEND continues with no gap.
- Reset, including mid-byte: the next cycle has `tx`=1, `busy`=0, `overflow`=0, pending empty and all counters at 0. Any partial frame is discarded and is not resumed.
- Reset values: `tx`=1, `busy`=0, `overflow`=0.

## Timing
- Latency: `din_valid` at cycle N while in IDLE gives `tx`=0 (start bit) and `busy`=1 from cycle N+1.
- Frame duration: NUM_BYTES*10*CLKS_PER_BIT cycles of `busy`=1 per frame.
- `busy` stays continuously high across chained frames.
- `busy` falls on the cycle after the final stop bit ends. `tx` is 1 at that point and stays 1.
- `tx` is registered, so no combinational path exists from `din`/`din_valid` to `tx`.
- Bit counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Byte index: counts 0..NUM_BYTES-1. Frame done is bit 9 of byte NUM_BYTES-1 with the counter at CLKS_PER_BIT-1.

## Structure
- Shared package `uart_pkg`:
  - Constants: START_BIT=0, STOP_BIT=1, BITS_PER_BYTE=8.
  - Byte-TX state encoding: IDLE, START, DATA, STOP.
- Sub-module `uart_tx_byte`:
  - Ports: `clk`, `rst`, `byte_in`[7:0], `byte_valid`, `byte_ready`, `tx`.
  - Parameter: CLKS_PER_BIT.
  - Its FSM: IDLE → START → DATA (8 bits) → STOP.
  - From STOP it goes to START if `byte_valid` is asserted in the last STOP cycle; otherwise it goes to IDLE.
  - `byte_ready` is high in IDLE and in the last STOP cycle.
- Top level owns the active and pending frame registers, the byte index, the `overflow` flag and the SEND/IDLE FSM.

## Test plan
All scenarios use WIDTH_DIN=16 and CLKS_PER_BIT=4.
- Reset: assert `rst` for 2 cycles → `tx`=1, `busy`=0, `overflow`=0, and these hold with no input activity.
- Single frame 16'hA55A:
  - Required `tx` sequence, each bit held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1, then 0, 0,1,0,1,1,0,1,0, 1.
  - `busy`=1 for exactly 80 cycles, starting the cycle after `din_valid`.
- Chained frames: send 16'hA55A, then 16'h0102 at cycle 10 → bytes A5, 5A, 01, 02 with no idle gap, `busy` high for 160 contiguous cycles, `overflow`=0.
- Overflow: three strobes at cycles 0, 5 and 6 → third frame dropped, `overflow`=1 from cycle 7, only two frames transmitted.
- Boundary: pending full and `din_valid` exactly on the frame-done cycle → three frames transmitted back-to-back, `overflow`=0.
- Mid-byte reset: assert `rst` during a data bit of byte 0 → next cycle `tx`=1, `busy`=0. A later frame 16'h00FF is transmitted correctly.
